// File: rtl/adc_spi_if.sv
// adc_spi_if: sample tick, SAR ADC SPI pins and captured-sample bundle for adc_spi_reader.
interface adc_spi_if #(
    parameter int NUM_BITS_OUTPUT = 24
);
    logic                       start_i;
    logic                       sdo_i;
    logic                       cnv_o;
    logic                       sck_o;
    logic [NUM_BITS_OUTPUT-1:0] data_o;
    logic                       valid_o;
    logic                       busy_o;
    logic                       overrun_o;
    modport master (
        output start_i, sdo_i,
        input  cnv_o, sck_o, data_o, valid_o, busy_o, overrun_o
    );
    modport slave (
        input  start_i, sdo_i,
        output cnv_o, sck_o, data_o, valid_o, busy_o, overrun_o
    );
endinterface

// File: rtl/adc_spi_reader.sv
// adc_spi_reader: triggers a SAR ADC conversion per sample tick and reads the result MSB first
// over a read-only SPI link, presenting it as a sign-extended word with a one-cycle valid strobe.
module adc_spi_reader #(
    parameter int NUM_BITS        = 24,
    parameter int NUM_BITS_OUTPUT = 24,
    parameter int CONV_CYCLES     = 30,
    parameter int CLK_DIV         = 1
) (
    input logic      clk_i,
    input logic      reset_i,
    adc_spi_if.slave bus
);
    localparam int CW = $clog2(CONV_CYCLES + 1);
    localparam int BW = $clog2(NUM_BITS + 1);
    localparam int PW = $clog2(CLK_DIV + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CONV  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    logic [1:0]                 state;
    logic [CW-1:0]              conv_cnt;
    logic [BW-1:0]              bit_cnt;
    logic [PW-1:0]              phase;
    logic signed [NUM_BITS-1:0] shift;
    logic                       phase_end;
    always_comb phase_end = phase == PW'(CLK_DIV - 1);
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= IDLE;
            conv_cnt      <= '0;
            bit_cnt       <= '0;
            phase         <= '0;
            shift         <= '0;
            bus.cnv_o     <= 1'b0;
            bus.sck_o     <= 1'b0;
            bus.data_o    <= '0;
            bus.valid_o   <= 1'b0;
            bus.busy_o    <= 1'b0;
            bus.overrun_o <= 1'b0;
        end else begin
            bus.valid_o   <= 1'b0;
            bus.overrun_o <= bus.start_i && state != IDLE;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        state      <= CONV;
                        bus.cnv_o  <= 1'b1;
                        bus.busy_o <= 1'b1;
                        conv_cnt   <= CW'(CONV_CYCLES - 1);
                    end
                end
                CONV: begin
                    if (conv_cnt == '0) begin
                        state     <= SHIFT;
                        bus.cnv_o <= 1'b0;
                        bus.sck_o <= 1'b0;
                        bit_cnt   <= BW'(NUM_BITS);
                        phase     <= '0;
                    end else begin
                        conv_cnt <= conv_cnt - CW'(1);
                    end
                end
                SHIFT: begin
                    if (phase_end) begin
                        phase     <= '0;
                        bus.sck_o <= ~bus.sck_o;
                        // sample on the rising SCK edge, count the bit once SCK falls again
                        if (!bus.sck_o) begin
                            shift <= {shift[NUM_BITS-2:0], bus.sdo_i};
                        end else begin
                            bit_cnt <= bit_cnt - BW'(1);
                            if (bit_cnt == BW'(1)) state <= DONE;
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    bus.data_o  <= NUM_BITS_OUTPUT'(shift);
                    bus.valid_o <= 1'b1;
                    bus.busy_o  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: timeline reference model plus ADC serial model checking adc_spi_reader every cycle.
module tb_adc_spi_reader;
    localparam int NB   = 24;
    localparam int NBO  = 32;
    localparam int CONV = 30;
    localparam int CD   = 1;
    localparam int L    = CONV + 2 * CD * NB + 1;

    logic clk_i = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk_i = ~clk_i;

    adc_spi_if #(.NUM_BITS_OUTPUT(NBO)) bus ();
    adc_spi_reader #(
        .NUM_BITS(NB), .NUM_BITS_OUTPUT(NBO), .CONV_CYCLES(CONV), .CLK_DIV(CD)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ADC serial model: latches its word when CNV rises, presents MSB after CNV falls,
    // advances one bit after each SCK rising edge.
    logic [NB-1:0] adc_word = '0;
    logic [NB-1:0] cur_word = '0;
    int bit_idx = 0;
    logic prev_cnv = 1'b0, prev_sck = 1'b0;
    always @(posedge clk_i) begin
        #1;
        if (bus.cnv_o && !prev_cnv) cur_word = adc_word;
        if (!bus.cnv_o && prev_cnv) bit_idx = NB - 1;
        else if (bus.sck_o && !prev_sck && bit_idx > 0) bit_idx--;
        bus.sdo_i = cur_word[bit_idx];
        prev_cnv = bus.cnv_o;
        prev_sck = bus.sck_o;
    end

    int sck_rises = 0;
    int ovr_count = 0;
    always @(posedge bus.sck_o) sck_rises++;
    always @(posedge clk_i) if (bus.overrun_o) ovr_count++;

    // Reference: t = cycles since the accepted start edge, -1 when idle.
    int t = -1;
    logic [31:0] m_data = '0;
    logic m_valid = 1'b0, m_ovr = 1'b0;
    logic [NB-1:0] m_word = '0;
    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            t = -1; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
        end else begin
            m_valid = 1'b0;
            m_ovr = bus.start_i && t >= 0;
            if (t >= 0) begin
                t++;
                if (t == L) begin
                    m_valid = 1'b1;
                    m_data = m_word[NB-1] ? {8'hFF, m_word} : {8'h00, m_word};
                    t = -1;
                end
            end else if (bus.start_i) begin
                t = 0;
                m_word = adc_word;
            end
        end
    end

    always @(negedge clk_i) begin
        check("cnv", 32'(bus.cnv_o), 32'(t >= 0 && t < CONV));
        check("sck", 32'(bus.sck_o), 32'(t >= CONV && t < CONV + 2 * CD * NB && ((t - CONV) / CD) % 2 == 1));
        check("busy", 32'(bus.busy_o), 32'(t >= 0));
        check("valid", 32'(bus.valid_o), 32'(m_valid));
        check("overrun", 32'(bus.overrun_o), 32'(m_ovr));
        check("data", bus.data_o, m_data);
    end

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.valid_o && n < 300) begin
            @(posedge clk_i); #1; n++;
        end
    endtask

    task automatic run_sample(input logic [NB-1:0] w, output int lat);
        @(negedge clk_i); adc_word = w; bus.start_i = 1'b1;
        @(posedge clk_i); #1 bus.start_i = 1'b0;
        wait_valid(lat);
    endtask

    initial begin
        int lat;
        bus.start_i = 1'b0;
        bus.sdo_i = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        repeat (200) @(negedge clk_i);
        check("idle_busy", 32'(bus.busy_o), 32'd0);
        check("idle_data", bus.data_o, 32'd0);

        run_sample(24'h5A5A5A, lat);
        check("lat_5a", lat, 32'd79);
        check("data_5a", bus.data_o, 32'h005A5A5A);
        repeat (5) @(posedge clk_i);

        run_sample(24'h800001, lat);
        check("data_neg", bus.data_o, 32'hFF800001);
        repeat (20) @(posedge clk_i);

        ovr_count = 0;
        for (int k = 0; k < 16; k++) begin
            run_sample(NB'(k), lat);
            check("ramp_lat", lat, 32'd79);
            check("ramp_data", bus.data_o, 32'(k));
            repeat (20) @(posedge clk_i);
        end
        check("ramp_ovr", ovr_count, 32'd0);

        sck_rises = 0;
        @(negedge clk_i); adc_word = 24'h123456; bus.start_i = 1'b1;
        @(posedge clk_i); #1 bus.start_i = 1'b0;
        repeat (39) @(posedge clk_i);
        @(negedge clk_i); adc_word = 24'hABCDEF; bus.start_i = 1'b1;
        @(posedge clk_i); #1 bus.start_i = 1'b0;
        check("ovr_pulse", 32'(bus.overrun_o), 32'd1);
        @(posedge clk_i); #1;
        check("ovr_once", 32'(bus.overrun_o), 32'd0);
        wait_valid(lat);
        check("ovr_lat", lat, 32'd38);
        check("ovr_data", bus.data_o, 32'h00123456);
        repeat (5) @(posedge clk_i);
        check("ovr_sck", sck_rises, 32'd24);

        sck_rises = 0;
        @(negedge clk_i); adc_word = 24'hFFFFFF; bus.start_i = 1'b1;
        @(posedge clk_i); #1 bus.start_i = 1'b0;
        lat = 0;
        while (sck_rises < 10 && lat < 300) begin
            @(posedge clk_i); #2; lat++;
        end
        check("rst_reach", 32'(sck_rises), 32'd10);
        reset_i = 1'b1;
        #1;
        check("rst_cnv", 32'(bus.cnv_o), 32'd0);
        check("rst_sck", 32'(bus.sck_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_data", bus.data_o, 32'd0);
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        repeat (3) @(negedge clk_i);
        run_sample(24'hC3A5F0, lat);
        check("post_rst_lat", lat, 32'd79);
        check("post_rst_data", bus.data_o, 32'hFFC3A5F0);

        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i); adc_word = NB'($urandom); bus.start_i = 1'b1;
            @(negedge clk_i); bus.start_i = 1'b0;
            repeat ($urandom_range(30, 110)) @(negedge clk_i);
        end
        repeat (100) @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
Front-end capture stage that produces the signed sample stream consumed by the input filter's `data_i` / tick pair.
- On each sample tick (`start_i`), drives a conversion-start pulse to an external SAR ADC.
- Clocks out the result over a read-only SPI link (SCK/SDO) and presents it as a two's-complement word with a one-cycle valid strobe.
- Runs entirely in the system clock domain (100 MHz). The ADC and SCK timing are derived by counters.

Parameters:
- NUM_BITS, 24, ADC word width (bits shifted per conversion, MSB first).
- NUM_BITS_OUTPUT, 24, width of `data_o`; must be >= NUM_BITS; result is sign-extended.
- CONV_CYCLES, 30, clk cycles `cnv_o` is held high (ADC conversion time).
- CLK_DIV, 1, SCK half-period in clk cycles (1 -> 50 MHz SCK).

Ports:
- clk_i, input, 1, system clock.
- reset_i, input, 1, asynchronous active-high reset.
- start_i, input, 1, single-cycle sample tick; requests one conversion.
- sdo_i, input, 1, ADC serial data, valid around SCK rising edge.
- cnv_o, output, 1, ADC conversion start, registered.
- sck_o, output, 1, SPI clock, registered, idles low.
- data_o, output, NUM_BITS_OUTPUT, last captured sample, signed, held until next capture.
- valid_o, output, 1, one-cycle strobe; `data_o` is new in the same cycle.
- busy_o, output, 1, high in any state other than IDLE.
- overrun_o, output, 1, one-cycle pulse when `start_i` arrives while busy.

Behaviour:
- All outputs are registered. Reset (async assert, sync-released by the system) forces:
  - state IDLE;
  - `cnv_o`, `sck_o`, `valid_o`, `busy_o`, `overrun_o` = 0;
  - `data_o` = 0;
  - shift register and counters = 0.
- Reset mid-conversion aborts immediately with no valid pulse. The next `start_i` after release starts a clean conversion.
- FSM states: IDLE, CONV, SHIFT, DONE.
- IDLE:
  - `start_i` = 1 at edge E0 -> CONV; `cnv_o` = 1 and `busy_o` = 1 from E0.
  - Otherwise stay in IDLE.
- CONV:
  - `cnv_o` stays high for exactly CONV_CYCLES cycles.
  - At the last of those edges: `cnv_o` -> 0, go to SHIFT, bit counter = NUM_BITS, phase counter = 0, `sck_o` low.
- SHIFT: each bit is CLK_DIV cycles with `sck_o` low, then CLK_DIV cycles with `sck_o` high.
  - `sdo_i` is shifted into the LSB of the shift register (MSB first overall) on the same edge that drives `sck_o` 0->1.
  - The bit counter decrements on the edge that drives `sck_o` 1->0.
  - When it reaches 0 -> DONE, with `sck_o` = 0.
  - Exactly NUM_BITS rising edges of `sck_o` per conversion.
- DONE (one cycle):
  - On its exit edge: `data_o` <= sign-extended shift register, `valid_o` = 1 for one cycle, `busy_o` = 0, state IDLE.
- Latency, start edge to the edge asserting `valid_o`: L = CONV_CYCLES + 2*CLK_DIV*NUM_BITS + 1. Defaults give 79 cycles.
- Throughput: the start period must be >= L + 1 cycles.
  - A `start_i` seen in any non-IDLE state is dropped.
  - A dropped start pulses `overrun_o` on the next cycle; the ongoing conversion is unaffected.
- `start_i` on the same edge that DONE returns to IDLE counts as busy: it is dropped and flagged.
- `data_o` changes only on a valid strobe. It is never partially updated.
- Width rule: `data_o[NUM_BITS_OUTPUT-1:NUM_BITS]` = copies of `shift[NUM_BITS-1]`.

Test Plan:
- Reset, no start for 200 cycles -> `cnv_o`/`sck_o`/`busy_o`/`valid_o` stay 0, `data_o` = 0.
- Single start, ADC model drives 0x5A5A5A -> `cnv_o` high exactly 30 cycles, then 24 SCK pulses (50 MHz), `valid_o` 79 cycles after the start edge, `data_o` = 0x5A5A5A.
- ADC model drives 0x800001 with NUM_BITS_OUTPUT = 32 -> `data_o` = 0xFF800001 (-8388607).
- Starts every 100 cycles for 16 samples, ramp 0..15 -> 16 valid strobes spaced 100 cycles, `data_o` = 0..15 in order, `overrun_o` never asserted.
- Second start 40 cycles after the first -> `overrun_o` pulse one cycle later, only one conversion (24 SCK edges), `data_o` from the first conversion.
- Assert `reset_i` during SHIFT after 10 bits -> outputs 0 immediately, no `valid_o`; next start yields correct full 24-bit sample.
